// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave in front of a 32-bit synchronous RAM; read and write channels are independent.
// Optional range checking with SLVERR responses is enabled by defining AXIL_RAM_ERR_RESP_EN.
module axil_ram_slave #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter              INIT_FILE = ""
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [31:0] s_axil_awaddr,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [31:0] s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic       {W_IDLE, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} rstate_t;

  logic [31:0] r_mem [DEPTH];

  wstate_t     r_wstate, w_wstate_nxt;
  rstate_t     r_rstate, w_rstate_nxt;
  logic        r_awready, r_wready, r_bvalid, r_aw_got, r_w_got;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_awaddr, r_wdata, r_araddr, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_arready, r_rvalid;

  logic        w_aw_hs, w_w_hs, w_commit, w_b_done, w_ar_hs, w_r_done;
  logic [31:0] w_awaddr, w_wdata, w_woff, w_roff;
  logic [3:0]  w_wstrb;
  logic        w_wr_ok, w_rd_ok;
  logic [AW-1:0] w_widx, w_ridx;

  // A beat captured on an earlier edge wins over the live bus value.
  assign w_aw_hs  = s_axil_awvalid && r_awready;
  assign w_w_hs   = s_axil_wvalid && r_wready;
  assign w_awaddr = r_aw_got ? r_awaddr : s_axil_awaddr;
  assign w_wdata  = r_w_got ? r_wdata : s_axil_wdata;
  assign w_wstrb  = r_w_got ? r_wstrb : s_axil_wstrb;
  assign w_woff   = w_awaddr - BASE_ADDR;
  assign w_roff   = r_araddr - BASE_ADDR;
  assign w_widx   = w_woff[AW+1:2];
  assign w_ridx   = w_roff[AW+1:2];

`ifdef AXIL_RAM_ERR_RESP_EN
  assign w_wr_ok = ({1'b0, w_woff} < SPAN);
  assign w_rd_ok = ({1'b0, w_roff} < SPAN);
`else
  assign w_wr_ok = 1'b1;
  assign w_rd_ok = 1'b1;
  logic w_unused_off;
  assign w_unused_off = ^{w_woff, w_roff};
`endif

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    w_b_done     = 1'b0;
    case (r_wstate)
      W_IDLE: if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
        w_commit     = 1'b1;
        w_wstate_nxt = W_RESP;
      end
      W_RESP: if (s_axil_bready) begin
        w_b_done     = 1'b1;
        w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_awready <= 1'b0;
        r_awaddr  <= s_axil_awaddr;
      end
      if (w_w_hs) begin
        r_wready <= 1'b0;
        r_wdata  <= s_axil_wdata;
        r_wstrb  <= s_axil_wstrb;
      end
      if (w_commit) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? 2'b00 : 2'b10;
      end else begin
        if (w_aw_hs) r_aw_got <= 1'b1;
        if (w_w_hs)  r_w_got  <= 1'b1;
      end
      if (w_b_done) begin
        r_bvalid  <= 1'b0;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
    end
  end

  // RAM is not reset; gating on i_Reset keeps a write from landing while reset is held.
  always_ff @(posedge i_Clock) begin
    if (w_commit && w_wr_ok && !i_Reset) begin
      for (int b = 0; b < 4; b++)
        if (w_wstrb[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  assign w_ar_hs = s_axil_arvalid && r_arready;
  assign w_r_done = (r_rstate == R_RESP) && s_axil_rready;

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_FETCH;
      R_FETCH: w_rstate_nxt = R_RESP;
      R_RESP:  if (s_axil_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_araddr  <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_araddr  <= s_axil_araddr;
        r_arready <= 1'b0;
      end
      // Non-blocking read of r_mem gives old data on a same-edge write.
      if (r_rstate == R_FETCH) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_ok ? r_mem[w_ridx] : 32'h0;
        r_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
      end
      if (w_r_done) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end
    end
  end

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: vector table through a response scoreboard, plus stall,
// early-W, collision and reset-mid-read sequences.
module tb_axil_ram_slave;
  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [3:0]  s_axil_wstrb;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;

  axil_ram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0000_1000), .INIT_FILE("")) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t        vecs[24];
  int          nv = 0;
  int          total = 0, bad = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input bit wr, input logic [31:0] a, d, input logic [3:0] s,
                     input logic [31:0] ed, input logic [1:0] er);
    vecs[nv] = '{wr, a, d, s, ed, er};
    nv++;
  endtask

  task automatic tick;
    @(posedge i_Clock); #1;
  endtask

  task automatic do_write(input logic [31:0] a, d, input logic [3:0] s, input logic [1:0] er);
    logic [1:0] e;
    bq.push_back(er);
    tick();
    s_axil_awaddr = a; s_axil_awvalid = 1; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_wvalid = 1; s_axil_bready = 1;
    tick();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    chk("b_lat", {s_axil_bvalid, s_axil_awready, s_axil_wready}, 3'b100);
    if (s_axil_bvalid) begin
      e = (bq.size() != 0) ? bq.pop_front() : 2'bxx;
      chk("bresp", s_axil_bresp, e);
    end
    tick();
    chk("b_done", {s_axil_bvalid, s_axil_awready, s_axil_wready}, 3'b011);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    logic [33:0] e;
    rq.push_back({er, ed});
    tick();
    s_axil_araddr = a; s_axil_arvalid = 1; s_axil_rready = 1;
    tick();
    s_axil_arvalid = 0;
    chk("ar_hs", {s_axil_rvalid, s_axil_arready}, 2'b00);
    tick();
    chk("r_lat", s_axil_rvalid, 1'b1);
    if (s_axil_rvalid) begin
      e = (rq.size() != 0) ? rq.pop_front() : 'x;
      chk("rdata", {s_axil_rresp, s_axil_rdata}, e);
    end
    tick();
    chk("r_done", {s_axil_rvalid, s_axil_arready}, 2'b01);
  endtask

  initial begin
    logic [31:0] held;
    i_Reset = 1;
    s_axil_awaddr = 0; s_axil_awvalid = 0; s_axil_wdata = 0; s_axil_wstrb = 0;
    s_axil_wvalid = 0; s_axil_bready = 0; s_axil_araddr = 0; s_axil_arvalid = 0;
    s_axil_rready = 0;
    repeat (3) @(posedge i_Clock);
    @(negedge i_Clock);
    chk("reset_state", {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid,
        s_axil_rvalid, s_axil_bresp, s_axil_rresp, s_axil_rdata}, {3'b111, 2'b00, 4'b0, 32'h0});
    tick();
    i_Reset = 0;

    add(1, 32'h1004, 32'hDEADBEEF, 4'hF, 0, 2'b00);
    add(0, 32'h1004, 0, 0, 32'hDEADBEEF, 2'b00);
    add(1, 32'h100C, 32'hFFFFFFFF, 4'hF, 0, 2'b00);
    add(1, 32'h100C, 32'h00000000, 4'b0101, 0, 2'b00);
    add(0, 32'h100C, 0, 0, 32'hFF00FF00, 2'b00);
    add(1, 32'h1010, 32'hAABBCCDD, 4'hF, 0, 2'b00);
    add(1, 32'h1010, 32'h00000000, 4'h0, 0, 2'b00);
    add(0, 32'h1010, 0, 0, 32'hAABBCCDD, 2'b00);
    add(1, 32'h1FFC, 32'h0BADF00D, 4'hF, 0, 2'b00);
    add(0, 32'h1FFC, 0, 0, 32'h0BADF00D, 2'b00);
    add(0, 32'h1007, 0, 0, 32'hDEADBEEF, 2'b00);
    add(1, 32'h1000, 32'h11111111, 4'hF, 0, 2'b00);
`ifdef AXIL_RAM_ERR_RESP_EN
    add(1, 32'h5000, 32'h55667788, 4'hF, 0, 2'b10);
    add(0, 32'h1000, 0, 0, 32'h11111111, 2'b00);
    add(0, 32'h0800, 0, 0, 32'h0, 2'b10);
    add(0, 32'h2000, 0, 0, 32'h0, 2'b10);
`else
    add(1, 32'h5000, 32'h55667788, 4'hF, 0, 2'b00);
    add(0, 32'h1000, 0, 0, 32'h55667788, 2'b00);
    add(0, 32'h2004, 0, 0, 32'hDEADBEEF, 2'b00);
`endif
    for (int i = 0; i < nv; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else            do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end

    // W beat ahead of AW: no response until the address arrives.
    bq.push_back(2'b00);
    tick();
    s_axil_wdata = 32'h0A0B0C0D; s_axil_wstrb = 4'hF; s_axil_wvalid = 1; s_axil_bready = 1;
    tick();
    s_axil_wvalid = 0;
    chk("early_w_cap", {s_axil_wready, s_axil_awready, s_axil_bvalid}, 3'b010);
    tick(); tick();
    chk("early_w_wait", {s_axil_wready, s_axil_bvalid}, 2'b00);
    s_axil_awaddr = 32'h1008; s_axil_awvalid = 1;
    tick();
    s_axil_awvalid = 0;
    chk("early_w_commit", {s_axil_bvalid, s_axil_awready}, 2'b10);
    if (s_axil_bvalid) chk("early_w_bresp", s_axil_bresp, bq.pop_front());
    tick();
    chk("early_w_done", {s_axil_bvalid, s_axil_awready, s_axil_wready}, 3'b011);
    do_read(32'h1008, 32'h0A0B0C0D, 2'b00);

    // Both response channels stalled for five cycles.
    tick();
    s_axil_awaddr = 32'h1014; s_axil_wdata = 32'hCAFEF00D; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 0;
    s_axil_araddr = 32'h1004; s_axil_arvalid = 1; s_axil_rready = 0;
    tick();
    s_axil_awaddr = 32'h1018; s_axil_araddr = 32'h100C; s_axil_wvalid = 0;
    tick();
    held = s_axil_rdata;
    chk("stall_rdata", held, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_arready,
          s_axil_rdata}, {4'b1100, held});
    end
    s_axil_awvalid = 0; s_axil_arvalid = 0;
    s_axil_bready = 1; s_axil_rready = 1;
    tick();
    chk("stall_release", {s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_arready}, 4'b0011);
    do_read(32'h1014, 32'hCAFEF00D, 2'b00);

    // Read edge coinciding with a commit to the same word returns the old word.
    do_write(32'h1018, 32'h11112222, 4'hF, 2'b00);
    tick();
    s_axil_araddr = 32'h1018; s_axil_arvalid = 1; s_axil_rready = 1;
    tick();
    s_axil_arvalid = 0;
    s_axil_awaddr = 32'h1018; s_axil_wdata = 32'h33334444; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 1;
    tick();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    chk("collide_old", {s_axil_rvalid, s_axil_bvalid, s_axil_rdata}, {2'b11, 32'h11112222});
    tick();
    do_read(32'h1018, 32'h33334444, 2'b00);

    // Reset while a read response is pending.
    tick();
    s_axil_araddr = 32'h1004; s_axil_arvalid = 1; s_axil_rready = 0;
    tick();
    s_axil_arvalid = 0;
    tick();
    chk("pre_reset_rvalid", s_axil_rvalid, 1'b1);
    i_Reset = 1;
    #1;
    chk("reset_async", {s_axil_rvalid, s_axil_arready, s_axil_rdata}, {2'b01, 32'h0});
    tick();
    i_Reset = 0;
    do_read(32'h1004, 32'hDEADBEEF, 2'b00);

    chk("sb_empty", {bq.size() == 0, rq.size() == 0}, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
